invaders_ram_arbiter: RTL and testbench



---
 rtl/invaders_pkg.sv | 17 +
 rtl/invaders_ram_clear.sv | 35 +++
 rtl/invaders_ram_arbiter.sv | 179 +++++++++++++++++
 tb/tb_invaders_ram_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/invaders_pkg.sv
// rtl/invaders_pkg.sv - shared types and defaults for the invaders RAM arbiter
package invaders_pkg;

    localparam int          RAM_AW_DEFAULT   = 13;
    localparam logic [15:0] RAM_BASE_DEFAULT = 16'h2000;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_VRD   = 3'd2,
        ST_VCAP  = 3'd3,
        ST_CRD   = 3'd4,
        ST_CCAP  = 3'd5,
        ST_CWR   = 3'd6
    } arb_state_t;

endpackage

// File: rtl/invaders_ram_clear.sv
// rtl/invaders_ram_clear.sv - power-on clear sweep counter with start/done handshake
module invaders_ram_clear #(
    parameter int AW             = 13,
    parameter bit START_ON_RESET = 1'b1
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          start,
    output logic          busy,
    output logic [AW-1:0] cnt,
    output logic          done
);

    localparam logic [AW-1:0] CNT_MAX = '1;

    // Walk the counter over every RAM offset once; busy drops with the final step
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            busy <= START_ON_RESET;
            cnt  <= '0;
        end else if (start && !busy) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            cnt <= cnt + AW'(1);
            if (cnt == CNT_MAX) begin
                busy <= 1'b0;
            end
        end
    end

    // done marks the cycle that issues the last sweep write
    assign done = busy && (cnt == CNT_MAX);

endmodule

// File: rtl/invaders_ram_arbiter.sv
// rtl/invaders_ram_arbiter.sv - shares the work/video RAM port between CPU and video fetch
module invaders_ram_arbiter
    import invaders_pkg::*;
#(
    parameter int          RAM_AW    = RAM_AW_DEFAULT,
    parameter logic [15:0] RAM_BASE  = RAM_BASE_DEFAULT,
    parameter bit          CLEAR_EN  = 1'b1,
    parameter logic [7:0]  CLEAR_VAL = 8'h00
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ready,
    input  logic              vid_req,
    input  logic [RAM_AW-1:0] vid_addr,
    output logic [7:0]        vid_data,
    output logic              vid_valid,
    output logic              vid_overrun,
    output logic [15:0]       ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_rw_n,
    input  logic [7:0]        ram_rdata,
    output logic              clearing
);

    localparam logic [16:0] RAM_SIZE = 17'(1) << RAM_AW;

    arb_state_t        state;
    logic              vid_pend;
    logic [RAM_AW-1:0] vid_addr_q;
    logic              last_vid;
    logic              clr_vid_d1;

    logic [RAM_AW-1:0] clr_cnt;
    logic              clr_busy;
    logic              clr_done;

    logic [15:0]       cpu_off;
    logic              cpu_in_win;
    logic [15:0]       cpu_ram_addr;
    logic [RAM_AW-1:0] vid_sel_addr;
    logic              cpu_elig;
    logic              vid_elig;
    logic              grant_vid;
    logic              grant_cpu;

    invaders_ram_clear #(
        .AW             (RAM_AW),
        .START_ON_RESET (CLEAR_EN)
    ) u_clear (
        .Clock (Clock),
        .Reset (Reset),
        .start (1'b0),
        .busy  (clr_busy),
        .cnt   (clr_cnt),
        .done  (clr_done)
    );

    // The sweep busy flag is itself a flop, so it serves directly as the clearing output
    assign clearing = clr_busy;

    // Window decode: offsets wrap in 16 bits, so addresses below the base fall out of window
    assign cpu_off      = cpu_addr - RAM_BASE;
    assign cpu_in_win   = {1'b0, cpu_off} < RAM_SIZE;
    assign cpu_ram_addr = RAM_BASE + 16'(cpu_off[RAM_AW-1:0]);

    // A fresh pulse supersedes the latched address, matching the overwrite-on-overrun rule
    assign vid_sel_addr = vid_req ? vid_addr : vid_addr_q;

    // The CPU is not re-granted in its own completion cycle
    assign cpu_elig  = cpu_req && !cpu_ready;
    assign vid_elig  = vid_pend || vid_req;
    assign grant_vid = (state == ST_IDLE) && vid_elig && !(last_vid && cpu_elig);
    assign grant_cpu = (state == ST_IDLE) && cpu_elig && !grant_vid;

    // Video request latch and sticky overrun flag; requests during the sweep are not queued
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            vid_pend    <= 1'b0;
            vid_addr_q  <= '0;
            vid_overrun <= 1'b0;
            clr_vid_d1  <= 1'b0;
        end else begin
            clr_vid_d1 <= vid_req && (state == ST_CLEAR);
            if (vid_req && (state != ST_CLEAR)) begin
                vid_addr_q <= vid_addr;
                if (vid_pend) begin
                    vid_overrun <= 1'b1;
                end
                vid_pend <= !grant_vid;
            end else if (grant_vid) begin
                vid_pend <= 1'b0;
            end
        end
    end

    // Main sequencer: sweep, arbitrate, run one RAM access and register the completion
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= CLEAR_EN ? ST_CLEAR : ST_IDLE;
            last_vid  <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_rw_n  <= 1'b1;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            vid_valid <= 1'b0;
            vid_data  <= '0;
        end else begin
            ram_rw_n  <= 1'b1;
            cpu_ready <= 1'b0;
            vid_valid <= 1'b0;
            if (clr_vid_d1) begin
                vid_valid <= 1'b1;
                vid_data  <= CLEAR_VAL;
            end
            case (state)
                ST_CLEAR: begin
                    ram_addr  <= RAM_BASE + 16'(clr_cnt);
                    ram_wdata <= CLEAR_VAL;
                    ram_rw_n  <= 1'b0;
                    if (clr_done) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (grant_vid) begin
                        last_vid <= 1'b1;
                        ram_addr <= RAM_BASE + 16'(vid_sel_addr);
                        state    <= ST_VRD;
                    end else if (grant_cpu) begin
                        last_vid <= 1'b0;
                        if (!cpu_in_win) begin
                            cpu_ready <= 1'b1;
                            cpu_rdata <= 8'h00;
                        end else begin
                            ram_addr <= cpu_ram_addr;
                            if (cpu_we) begin
                                ram_wdata <= cpu_wdata;
                                ram_rw_n  <= 1'b0;
                                state     <= ST_CWR;
                            end else begin
                                state <= ST_CRD;
                            end
                        end
                    end
                end
                ST_VRD: begin
                    state <= ST_VCAP;
                end
                ST_VCAP: begin
                    vid_data  <= ram_rdata;
                    vid_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                ST_CRD: begin
                    state <= ST_CCAP;
                end
                ST_CCAP: begin
                    cpu_rdata <= ram_rdata;
                    cpu_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                ST_CWR: begin
                    cpu_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_invaders_ram_arbiter.sv
// tb/tb_invaders_ram_arbiter.sv - self-checking bench for invaders_ram_arbiter
module tb_invaders_ram_arbiter;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic        vid_req = 1'b0;
    logic [12:0] vid_addr = 13'h0000;
    logic [7:0]  vid_data;
    logic        vid_valid;
    logic        vid_overrun;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_rw_n;
    logic [7:0]  ram_rdata;
    logic        clearing;

    logic [7:0]  mem [0:8191];
    logic [7:0]  model [0:8191];
    logic        fill_req = 1'b0;
    logic [7:0]  fill_val = 8'h00;
    logic        poke_req = 1'b0;
    logic [12:0] poke_addr = 13'h0000;
    logic [7:0]  poke_data = 8'h00;
    logic [15:0] ram_off;

    int total = 0;
    int bad = 0;

    invaders_ram_arbiter dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ready   (cpu_ready),
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_data    (vid_data),
        .vid_valid   (vid_valid),
        .vid_overrun (vid_overrun),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rw_n    (ram_rw_n),
        .ram_rdata   (ram_rdata),
        .clearing    (clearing)
    );

    always #5 Clock = ~Clock;

    assign ram_off = ram_addr - 16'h2000;

    // Memory block: synchronous write when RW_n is low, registered read data
    always @(posedge Clock) begin
        if (fill_req) begin
            for (int i = 0; i < 8192; i++) mem[i] <= fill_val;
        end else if (poke_req) begin
            mem[poke_addr] <= poke_data;
        end else if (!ram_rw_n) begin
            mem[ram_off[12:0]] <= ram_wdata;
        end
        ram_rdata <= mem[ram_off[12:0]];
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [12:0] a, input logic [7:0] d);
        poke_addr = a;
        poke_data = d;
        poke_req  = 1'b1;
        tick();
        poke_req  = 1'b0;
        model[a]  = d;
    endtask

    task automatic cpu_op(input logic we, input logic [15:0] a, input logic [7:0] d);
        int n;
        int lows;
        logic [15:0] off;
        logic inwin;
        logic [7:0] exp;
        off   = a - 16'h2000;
        inwin = off < 16'd8192;
        exp   = inwin ? model[off[12:0]] : 8'h00;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        n = 0; lows = 0;
        do begin
            tick();
            n++;
            if (!ram_rw_n) lows++;
        end while (!cpu_ready && n < 12);
        cpu_req = 1'b0;
        check("cpu_latency", n, !inwin ? 1 : (we ? 2 : 3));
        check("cpu_rw_low_cycles", lows, (inwin && we) ? 1 : 0);
        if (!we) check("cpu_rdata", cpu_rdata, exp);
        if (we && inwin) model[off[12:0]] = d;
        tick();
    endtask

    task automatic vid_op(input logic [12:0] a);
        int n;
        vid_req = 1'b1; vid_addr = a; n = 0;
        do begin
            tick();
            n++;
            vid_req = 1'b0;
        end while (!vid_valid && n < 12);
        check("vid_latency", n, 3);
        check("vid_data", vid_data, model[a]);
        tick();
    endtask

    initial begin
        int clr_hi, rw_lo, vv_cnt, vv_cyc, cr_cyc, nonzero;
        logic [7:0] vv_dat, cr_dat;
        int vcyc[$];
        logic [7:0] vdat[$];
        logic [15:0] last_wr;
        logic [15:0] bnd [6];
        bnd = '{16'h2000, 16'h3FFF, 16'h1FFF, 16'h4000, 16'h0000, 16'hFFFF};

        // Reset with RAM preloaded to 0xAA
        fill_val = 8'hAA; fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        tick();
        check("rst_ram_rw_n", ram_rw_n, 1);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_vid_valid", vid_valid, 0);
        check("rst_vid_data", vid_data, 0);
        check("rst_vid_overrun", vid_overrun, 0);
        check("rst_clearing", clearing, 1);

        // Clear sweep; a video pulse and a CPU read arrive while it runs
        Reset = 1'b0;
        clr_hi = 0; rw_lo = 0; vv_cnt = 0; vv_cyc = -1; cr_cyc = -1;
        vv_dat = 8'hFF; cr_dat = 8'hFF;
        for (int k = 0; k < 8300; k++) begin
            if (clearing) clr_hi++;
            if (!ram_rw_n) rw_lo++;
            if (vid_valid) begin vv_cnt++; vv_cyc = k; vv_dat = vid_data; end
            if (cpu_ready) begin cr_cyc = k; cr_dat = cpu_rdata; cpu_req = 1'b0; end
            vid_req  = (k == 100);
            vid_addr = 13'h0123;
            if (k == 8000) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2005; end
            tick();
        end
        cpu_req = 1'b0; vid_req = 1'b0;
        check("clr_clearing_cycles", clr_hi, 8192);
        check("clr_rw_low_cycles", rw_lo, 8192);
        check("clr_vid_count", vv_cnt, 1);
        check("clr_vid_cycle", vv_cyc, 102);
        check("clr_vid_data", vv_dat, 8'h00);
        check("clr_cpu_ready_cycle", cr_cyc, 8195);
        check("clr_cpu_rdata", cr_dat, 8'h00);
        check("clr_no_overrun", vid_overrun, 0);
        nonzero = 0;
        for (int i = 0; i < 8192; i++) begin
            if (mem[i] !== 8'h00) nonzero++;
            model[i] = 8'h00;
        end
        check("clr_ram_nonzero_bytes", nonzero, 0);

        // Single video fetch and CPU write/read
        poke(13'h0400, 8'h5C);
        vid_op(13'h0400);
        cpu_op(1'b1, 16'h2401, 8'h3E);
        cpu_op(1'b0, 16'h2401, 8'h00);

        // Simultaneous CPU and video, second video pulse 3 cycles later
        poke(13'h0010, 8'h11);
        poke(13'h1FFF, 8'h22);
        vcyc.delete(); vdat.delete(); cr_cyc = -1; cr_dat = 8'hFF;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2000;
        for (int k = 0; k < 16; k++) begin
            if (vid_valid) begin vcyc.push_back(k); vdat.push_back(vid_data); end
            if (cpu_ready) begin cr_cyc = k; cr_dat = cpu_rdata; cpu_req = 1'b0; end
            vid_req  = (k == 0) || (k == 3);
            vid_addr = (k == 0) ? 13'h0010 : 13'h1FFF;
            tick();
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        check("cont_vid_count", vcyc.size(), 2);
        check("cont_vid1_cycle", (vcyc.size() > 0) ? vcyc[0] : -1, 3);
        check("cont_vid1_data", (vdat.size() > 0) ? vdat[0] : 8'hFF, model[13'h0010]);
        check("cont_cpu_cycle", cr_cyc, 6);
        check("cont_cpu_rdata", cr_dat, model[13'h0000]);
        check("cont_vid2_cycle", (vcyc.size() > 1) ? vcyc[1] : -1, 9);
        check("cont_vid2_data", (vdat.size() > 1) ? vdat[1] : 8'hFF, model[13'h1FFF]);
        check("cont_no_overrun", vid_overrun, 0);
        tick();

        // Out-of-window and boundary accesses
        cpu_op(1'b0, 16'h4000, 8'h00);
        cpu_op(1'b1, 16'h1FFF, 8'h77);
        cpu_op(1'b1, 16'h3FFF, 8'h9A);
        cpu_op(1'b0, 16'h3FFF, 8'h00);
        cpu_op(1'b0, 16'h2000, 8'h00);

        // Random mix checked against the shadow memory and fixed latencies
        last_wr = 16'h2401;
        for (int i = 0; i < 150; i++) begin
            int kind, sel;
            logic [15:0] a;
            kind = int'($urandom_range(0, 3));
            sel  = int'($urandom_range(0, 7));
            if (sel <= 4) a = 16'h2000 + 16'($urandom_range(0, 8191));
            else if (sel == 5) a = last_wr;
            else if (sel == 6) a = bnd[$urandom_range(0, 5)];
            else a = 16'($urandom);
            if (kind == 0) begin
                vid_op(13'($urandom_range(0, 8191)));
            end else if (kind == 1) begin
                cpu_op(1'b1, a, 8'($urandom));
                last_wr = a;
            end else begin
                cpu_op(1'b0, a, 8'h00);
            end
        end
        vid_op(13'h1FFF);

        // Two video pulses back to back while a CPU read is in flight
        poke(13'h0020, 8'h31);
        poke(13'h0021, 8'h32);
        vcyc.delete(); vdat.delete(); cr_cyc = -1; cr_dat = 8'hFF;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2401;
        for (int k = 0; k < 16; k++) begin
            if (vid_valid) begin vcyc.push_back(k); vdat.push_back(vid_data); end
            if (cpu_ready) begin cr_cyc = k; cr_dat = cpu_rdata; cpu_req = 1'b0; end
            vid_req  = (k == 1) || (k == 2);
            vid_addr = (k == 1) ? 13'h0020 : 13'h0021;
            tick();
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        check("ovr_cpu_cycle", cr_cyc, 3);
        check("ovr_cpu_rdata", cr_dat, model[13'h0401]);
        check("ovr_vid_count", vcyc.size(), 1);
        check("ovr_vid_cycle", (vcyc.size() > 0) ? vcyc[0] : -1, 6);
        check("ovr_vid_data", (vdat.size() > 0) ? vdat[0] : 8'hFF, 8'h32);
        check("ovr_flag", vid_overrun, 1);
        tick();

        // Asynchronous reset in the middle of a CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2401;
        tick();
        check("crd_ram_addr", ram_addr, 16'h2401);
        #1;
        Reset = 1'b1;
        #1;
        check("arst_ram_addr", ram_addr, 0);
        check("arst_ram_rw_n", ram_rw_n, 1);
        check("arst_ram_wdata", ram_wdata, 0);
        check("arst_cpu_ready", cpu_ready, 0);
        check("arst_cpu_rdata", cpu_rdata, 0);
        check("arst_vid_valid", vid_valid, 0);
        check("arst_vid_data", vid_data, 0);
        check("arst_vid_overrun", vid_overrun, 0);
        check("arst_clearing", clearing, 1);
        cpu_req = 1'b0;
        tick();
        tick();
        check("arst_no_completion", cpu_ready, 0);
        Reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
